ahb_sram_slave: RTL

AHB slave (responder) backed by an internal word-addressed memory. It is the far end of the `ahb_master` bus interface, so the master can be exercised against a real responder instead of a random-`HREADY` stub. It supports:
- byte, halfword and word transfers;
- a configurable number of wait states;
- the two-cycle AHB ERROR response for illegal accesses.

---
 rtl/ahb_sram_slave.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB responder backed by a word-addressed SRAM: byte/half/word access,
// programmable wait states and the two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned DATA_WDT    = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                i_hclk,
    input  logic                i_hreset_n,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hready,
    output logic [1:0]          o_hresp
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_W = IDX_W + 2;
    localparam int unsigned NBYTES = DATA_WDT / 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                write_q, write_d;
    logic                accept;
    logic                commit;
    logic                misalign;
    logic                illegal;
    logic [NBYTES-1:0]   be;
    logic [DATA_WDT-1:0] rd_word;
    logic [DATA_WDT-1:0] mem [DEPTH_WORDS];
    logic                unused_ok;

    assign unused_ok = ^{i_hburst, i_htrans[0]};

    assign misalign = ((i_hsize == 3'd1) && i_haddr[0]) ||
                      ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00));
    assign illegal  = (i_hsize > 3'd2) || misalign || ({1'b0, i_haddr} >= ADDR_LIMIT);

    // Next-state: IDLE, DATA and ERR2 all end a data phase and may open a new one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                commit  = (state_q == ST_DATA) && write_q;
                accept  = i_hsel && i_hready && i_htrans[1];
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = i_haddr[ADDR_W-1:0];
                    size_d  = i_hsize[1:0];
                    write_d = i_hwrite;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    // Byte-lane enables of the transfer currently in its data phase
    always_comb begin
        be = '0;
        case (size_q)
            2'd0:    be[addr_q[1:0]] = 1'b1;
            2'd1:    be = addr_q[1] ? NBYTES'(4'b1100) : NBYTES'(4'b0011);
            default: be = '1;
        endcase
    end

    // Read word for the next data phase, forwarding a write that commits on the same edge
    always_comb begin
        rd_word = mem[addr_d[ADDR_W-1:2]];
        if (commit && (addr_d[ADDR_W-1:2] == addr_q[ADDR_W-1:2])) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_hclk) begin
        if (commit) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem[addr_q[ADDR_W-1:2]][8*b +: 8] <= i_hwdata[8*b +: 8];
                end
            end
        end
    end

    // State register; outputs are decoded from the next state so they are flop-driven
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            o_hready <= 1'b1;
            o_hresp  <= RESP_OKAY;
            o_hrdata <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            o_hready <= !((state_d == ST_WAIT) || (state_d == ST_ERR1));
            o_hresp  <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
            o_hrdata <= ((state_d == ST_DATA) && !write_d) ? rd_word : '0;
        end
    end

endmodule
